cgra_config_responder: RTL
==========================

# cgra_config_responder

Per-tile configuration responder for the CGRA: the receiving end of the `config_addr_in`/`config_data_in` bus the system bench drives into `top`. It decodes each bus transaction against its own tile ID, writes matching words into a local configuration register file that drives the tile's datapath, and serves read-back requests by shifting the addressed register out MSB-first on a 1-bit return line. One instance sits in every tile; non-matching transactions are ignored so that all tiles can share the bus.

## Interface
- `TILE_ID`, 16'h0015, tile address matched against `config_addr_in[15:0]`
- `NUM_REGS`, 8, number of 32-bit configuration registers (1..256)
- `clk_in` input 1: the only clock; all state updates on the rising edge
- `reset_in` input 1: synchronous, active-high
- `config_valid_in` input 1: transaction present this cycle
- `config_ready_out` output 1: responder can accept; transfer occurs on the edge where valid && ready
- `config_read_in` input 1: 1 = read-back request, 0 = write
- `config_addr_in` input 32: [15:0] tile ID, [23:16] register index, [31:24] ignored
- `config_data_in` input 32: write data (ignored on reads)
- `cfg_regs_out` output NUM_REGS*32: flat register file, reg i at [32*i+31:32*i]
- `read_data_out` output 1: serial read-back bit
- `read_valid_out` output 1: `read_data_out` is meaningful this cycle
- `cfg_err_out` output 1: sticky; set by a matching transaction with index >= NUM_REGS

## Operation
- FSM states: IDLE, SHIFT.
- IDLE: `config_ready_out`=1. On an accepted transaction, `match` = (addr[15:0]==TILE_ID).
  - Write, match, index < NUM_REGS: register[index] <= data.
  - Write or read, match, index >= NUM_REGS: no register change, `cfg_err_out` <= 1. A read additionally shifts 32 zeros (enters SHIFT with shift register = 0).
  - Read, match, index < NUM_REGS: shift register <= register[index], bit counter <= 31, go to SHIFT.
  - No match: ignored entirely, including the error flag; stay IDLE.
- SHIFT: `config_ready_out`=0, `read_valid_out`=1, `read_data_out` = shift register[31]. Each cycle shift left by one and decrement the counter. On the cycle the counter is 0, return to IDLE.
- `config_valid_in` during SHIFT is not accepted. The initiator holds it, per the handshake rule.
- Register file contents are unaffected by reads. A read captures the value at acceptance.
- Reset: all registers 0, `cfg_err_out`=0, state IDLE, shift register 0. Reset asserted mid-SHIFT aborts the read on the next edge.

## Timing
- Reset values: `config_ready_out`=1, `read_valid_out`=0, `read_data_out`=0, `cfg_regs_out`=0, `cfg_err_out`=0.
- Write accepted at edge N: `cfg_regs_out` shows the new value after edge N (1-cycle latency).
- Read accepted at edge N: bit 31 is on `read_data_out` with `read_valid_out`=1 during cycle N+1. Bit 0 is on the line during cycle N+32. `config_ready_out` returns to 1 in cycle N+33.
- Back-to-back writes: one per cycle, no bubbles.
- Write immediately after a read: accepted at the earliest at edge N+33.
- `cfg_err_out` rises the cycle after the offending edge and stays high until reset.

## Structure
- Shared package `cgra_cfg_pkg`:
  - address field constants `CFG_TILE_LSB`=0, `CFG_TILE_W`=16, `CFG_REG_LSB`=16, `CFG_REG_W`=8;
  - `CFG_DATA_W`=32;
  - state enum `cfg_state_t` {IDLE, SHIFT}.
- Sub-module `config_readback_shifter`:
  - ports: load, 32-bit load value, serial out, valid, done;
  - contents: the 32-bit shift register and 5-bit counter.
- The parent holds the decode, the register file, the error flag and the FSM.

## Test plan
- Reset, then write addr=32'h0003_0015, data=32'hDEAD_BEEF → reg 3 = DEADBEEF on the next cycle; all other regs 0; `cfg_err_out`=0.
- Write addr=32'h0003_0016 (other tile) → no register change, `cfg_err_out` stays 0, ready stays 1.
- After the first write, read addr=32'h0003_0015 → 32 valid cycles of serial bits 1101_1110_1010_1101_1011_1110_1110_1111, ready low for exactly 32 cycles. A valid write held during those cycles is accepted only in cycle N+33.
- Write addr=32'h0009_0015 with NUM_REGS=8 → no register change, `cfg_err_out`=1 from the next cycle and sticky. A read of index 9 returns 32 zeros.
- Eight back-to-back writes to regs 0..7 with data=i*32'h1111_1111 → each value visible one cycle after its edge, no stalls.
- Reset asserted at the 10th bit of a read → next cycle `read_valid_out`=0, ready=1, all regs 0.

Source files
------------

// File: rtl/cgra_cfg_pkg.sv
// ---------------------------------------------------------------------------
// cgra_cfg_pkg
// Shared definitions for the per-tile configuration bus:
//   - field positions inside config_addr_in (tile ID, register index)
//   - configuration data width and read-back counter width
//   - responder FSM state encoding
//   - helpers that extract the address fields
// ---------------------------------------------------------------------------
package cgra_cfg_pkg;

  localparam int CFG_TILE_LSB = 0;
  localparam int CFG_TILE_W   = 16;
  localparam int CFG_REG_LSB  = 16;
  localparam int CFG_REG_W    = 8;
  localparam int CFG_DATA_W   = 32;
  localparam int CFG_CNT_W    = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } cfg_state_t;

  function automatic logic [CFG_TILE_W-1:0] cfg_tile_of(input logic [31:0] addr);
    return addr[CFG_TILE_LSB +: CFG_TILE_W];
  endfunction

  function automatic logic [CFG_REG_W-1:0] cfg_reg_of(input logic [31:0] addr);
    return addr[CFG_REG_LSB +: CFG_REG_W];
  endfunction

endpackage

// File: rtl/config_readback_shifter.sv
// ---------------------------------------------------------------------------
// config_readback_shifter
// Serialises one 32-bit configuration word MSB-first.
//   clk_in, reset_in : clock, synchronous active-high reset
//   load_in          : capture load_val_in and start a 32-bit burst
//   load_val_in      : word to serialise
//   serial_out       : current bit (shift register MSB)
//   valid_out        : a burst is in progress, serial_out is meaningful
//   done_out         : the bit on serial_out this cycle is the last one
// ---------------------------------------------------------------------------
module config_readback_shifter
  import cgra_cfg_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  load_in,
  input  logic [CFG_DATA_W-1:0] load_val_in,
  output logic                  serial_out,
  output logic                  valid_out,
  output logic                  done_out
);

  logic [CFG_DATA_W-1:0] sr_q, sr_d;
  logic [CFG_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  valid_q, valid_d;

  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load_in) begin
      sr_d    = load_val_in;
      cnt_d   = CFG_CNT_W'(CFG_DATA_W - 1);
      valid_d = 1'b1;
    end else if (valid_q) begin
      // After the final shift all bits have left, so sr_q idles at zero
      // and serial_out reads 0 between bursts.
      sr_d  = {sr_q[CFG_DATA_W-2:0], 1'b0};
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign serial_out = sr_q[CFG_DATA_W-1];
  assign valid_out  = valid_q;
  assign done_out   = valid_q && (cnt_q == '0);

endmodule

// File: rtl/cgra_config_responder.sv
// ---------------------------------------------------------------------------
// cgra_config_responder
// Per-tile receiver on the shared configuration bus. Transactions whose tile
// field equals TILE_ID write the local register file or request a serial
// read-back of one register; all other transactions are ignored.
//   clk_in, reset_in  : clock, synchronous active-high reset
//   config_valid_in   : transaction present
//   config_ready_out  : responder can accept (IDLE only)
//   config_read_in    : 1 = read-back, 0 = write
//   config_addr_in    : [15:0] tile ID, [23:16] register index
//   config_data_in    : write data
//   cfg_regs_out      : flat register file, reg i at [32*i +: 32]
//   read_data_out     : serial read-back bit, MSB first
//   read_valid_out    : read_data_out meaningful this cycle
//   cfg_err_out       : sticky out-of-range index flag
//   state_dbg_out     : current FSM state
//
// Handshake: a transaction transfers on the rising edge where
// config_valid_in && config_ready_out; the initiator keeps valid and the
// payload stable until that edge. Ready is low for the whole read-back.
// ---------------------------------------------------------------------------
module cgra_config_responder
  import cgra_cfg_pkg::*;
#(
  parameter logic [15:0] TILE_ID  = 16'h0015,
  parameter int          NUM_REGS = 8
) (
  input  logic                           clk_in,
  input  logic                           reset_in,
  input  logic                           config_valid_in,
  output logic                           config_ready_out,
  input  logic                           config_read_in,
  input  logic [31:0]                    config_addr_in,
  input  logic [CFG_DATA_W-1:0]          config_data_in,
  output logic [NUM_REGS*CFG_DATA_W-1:0] cfg_regs_out,
  output logic                           read_data_out,
  output logic                           read_valid_out,
  output logic                           cfg_err_out,
  output cfg_state_t                     state_dbg_out
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  // 9 bits so that NUM_REGS = 256 is representable for the range check.
  localparam logic [CFG_REG_W:0] NUM_REGS_C = (CFG_REG_W + 1)'(NUM_REGS);

  cfg_state_t            state_q, state_d;
  logic [CFG_DATA_W-1:0] cfg_regs_q [NUM_REGS];
  logic [CFG_DATA_W-1:0] cfg_regs_d [NUM_REGS];
  logic                  err_q, err_d;

  logic                  accept;
  logic                  match;
  logic                  in_range;
  logic [CFG_REG_W-1:0]  reg_idx;
  logic [IDX_W-1:0]      idx;
  logic                  shift_load;
  logic [CFG_DATA_W-1:0] shift_val;
  logic                  shift_valid;
  logic                  shift_done;
  logic                  shift_bit;

  assign config_ready_out = (state_q == IDLE);
  assign accept   = config_valid_in && config_ready_out;
  assign match    = (cfg_tile_of(config_addr_in) == TILE_ID);
  assign reg_idx  = cfg_reg_of(config_addr_in);
  assign in_range = ({1'b0, reg_idx} < NUM_REGS_C);
  assign idx      = reg_idx[IDX_W-1:0];

  always_comb begin
    state_d    = state_q;
    cfg_regs_d = cfg_regs_q;
    err_d      = err_q;
    shift_load = 1'b0;
    shift_val  = '0;
    case (state_q)
      IDLE: begin
        if (accept && match) begin
          if (in_range) begin
            if (config_read_in) begin
              // The word is captured now; later writes do not affect it.
              shift_load = 1'b1;
              shift_val  = cfg_regs_q[idx];
              state_d    = SHIFT;
            end else begin
              cfg_regs_d[idx] = config_data_in;
            end
          end else begin
            err_d = 1'b1;
            if (config_read_in) begin
              // Out-of-range read still occupies the line for a full word.
              shift_load = 1'b1;
              state_d    = SHIFT;
            end
          end
        end
      end
      SHIFT: begin
        if (shift_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        cfg_regs_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      cfg_regs_q <= cfg_regs_d;
    end
  end

  config_readback_shifter u_shifter (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .load_in     (shift_load),
    .load_val_in (shift_val),
    .serial_out  (shift_bit),
    .valid_out   (shift_valid),
    .done_out    (shift_done)
  );

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign cfg_regs_out[g*CFG_DATA_W +: CFG_DATA_W] = cfg_regs_q[g];
  end

  assign read_data_out  = shift_bit;
  assign read_valid_out = shift_valid;
  assign cfg_err_out    = err_q;
  assign state_dbg_out  = state_q;

endmodule
